// File: rtl/range_session_arbiter.sv
// range_session_arbiter
// Round-robin owner of a shared min/max range tracker. One requester at a time
// gets a measurement session. Its samples are streamed into the tracker, the
// tracker is sequenced with go/finish pulses, and the measured range is returned
// tagged with the owner's ID. All outputs are registered, so tracker pulses and
// data appear one cycle after the sample that caused them.
module range_session_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         smp_valid,
    input  logic [NREQ-1:0]         smp_last,
    input  logic [NREQ*WIDTH-1:0]   smp_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    trk_go,
    output logic                    trk_finish,
    output logic [WIDTH-1:0]        trk_data,
    input  logic [WIDTH-1:0]        trk_range,
    input  logic                    trk_error,
    output logic                    res_valid,
    output logic [WIDTH-1:0]        res_range,
    output logic [IDW-1:0]          res_id,
    output logic                    res_timeout,
    output logic                    proto_err
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACTIVE = 2'd2,
        S_FIN1   = 2'd3
    } state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IDW-1:0]    gid_q;
    logic [IDW-1:0]    ptr_q;
    logic [CNTW-1:0]   cnt_q;
    logic              trk_go_q;
    logic              trk_finish_q;
    logic [WIDTH-1:0]  trk_data_q;
    // end_q marks the cycle a session closes; abort_q says whether it timed out
    logic              end_q;
    logic              abort_q;
    logic              res_valid_q;
    logic [WIDTH-1:0]  res_range_q;
    logic [IDW-1:0]    res_id_q;
    logic              res_timeout_q;
    logic              proto_err_q;

    logic              pick_vld_d;
    logic [IDW-1:0]    pick_id_d;
    logic [IDW-1:0]    cand_d;
    logic              g_valid_d;
    logic              g_last_d;
    logic [WIDTH-1:0]  g_data_d;
    logic [CNTW-1:0]   cnt_inc_d;
    logic              tmo_d;
    logic [IDW-1:0]    ptr_nxt_d;

    // Round-robin pick: first requesting index at or after the pointer, wrapping
    always_comb begin
        pick_vld_d = 1'b0;
        pick_id_d  = '0;
        cand_d     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_d = IDW'((int'(ptr_q) + k) % NREQ);
            if (!pick_vld_d && req[cand_d]) begin
                pick_vld_d = 1'b1;
                pick_id_d  = cand_d;
            end
        end
    end

    // Granted requester's sample lane, idle-cycle counter and next pointer
    always_comb begin
        g_valid_d = smp_valid[gid_q];
        g_last_d  = smp_last[gid_q];
        g_data_d  = smp_data[int'(gid_q)*WIDTH +: WIDTH];
        cnt_inc_d = cnt_q + CNTW'(1);
        tmo_d     = (cnt_inc_d == CNTW'(TIMEOUT));
        if (int'(gid_q) == NREQ - 1) begin
            ptr_nxt_d = '0;
        end else begin
            ptr_nxt_d = gid_q + IDW'(1);
        end
    end

    // Session FSM with registered tracker controls and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            gid_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            trk_go_q      <= 1'b0;
            trk_finish_q  <= 1'b0;
            trk_data_q    <= '0;
            end_q         <= 1'b0;
            abort_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_range_q   <= '0;
            res_id_q      <= '0;
            res_timeout_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            trk_go_q     <= 1'b0;
            trk_finish_q <= 1'b0;
            end_q        <= 1'b0;

            if (trk_error) begin
                proto_err_q <= 1'b1;
            end

            // The tracker range is valid in the finish cycle, which is the end_q cycle
            res_valid_q <= end_q;
            if (end_q) begin
                res_range_q   <= abort_q ? '0 : trk_range;
                res_id_q      <= gid_q;
                res_timeout_q <= abort_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        gnt_q   <= NREQ'(1) << pick_id_d;
                        gid_q   <= pick_id_d;
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (g_valid_d) begin
                        trk_go_q   <= 1'b1;
                        trk_data_q <= g_data_d;
                        cnt_q      <= '0;
                        state_q    <= g_last_d ? S_FIN1 : S_ACTIVE;
                    end else if (tmo_d) begin
                        // No tracker pulses were issued, so nothing to finish
                        gnt_q   <= '0;
                        end_q   <= 1'b1;
                        abort_q <= 1'b1;
                        ptr_q   <= ptr_nxt_d;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_ACTIVE: begin
                    if (g_valid_d) begin
                        trk_data_q <= g_data_d;
                        cnt_q      <= '0;
                        if (g_last_d) begin
                            trk_finish_q <= 1'b1;
                            gnt_q        <= '0;
                            end_q        <= 1'b1;
                            abort_q      <= 1'b0;
                            ptr_q        <= ptr_nxt_d;
                            state_q      <= S_IDLE;
                        end
                    end else if (tmo_d) begin
                        // Close the tracker session with data held; its range is discarded
                        trk_finish_q <= 1'b1;
                        gnt_q        <= '0;
                        end_q        <= 1'b1;
                        abort_q      <= 1'b1;
                        ptr_q        <= ptr_nxt_d;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_FIN1: begin
                    trk_finish_q <= 1'b1;
                    gnt_q        <= '0;
                    end_q        <= 1'b1;
                    abort_q      <= 1'b0;
                    ptr_q        <= ptr_nxt_d;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign trk_go      = trk_go_q;
    assign trk_finish  = trk_finish_q;
    assign trk_data    = trk_data_q;
    assign res_valid   = res_valid_q;
    assign res_range   = res_range_q;
    assign res_id      = res_id_q;
    assign res_timeout = res_timeout_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter with a small behavioural min/max
// tracker attached to the trk_* side.
module tb_range_session_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       smp_valid;
    logic [NREQ-1:0]       smp_last;
    logic [NREQ*WIDTH-1:0] smp_data;
    logic [NREQ-1:0]       gnt;
    logic                  trk_go;
    logic                  trk_finish;
    logic [WIDTH-1:0]      trk_data;
    logic [WIDTH-1:0]      trk_range;
    logic                  trk_error;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_range;
    logic                  res_id;
    logic                  res_timeout;
    logic                  proto_err;

    int nvec = 0;
    int nerr = 0;

    range_session_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .smp_valid  (smp_valid),
        .smp_last   (smp_last),
        .smp_data   (smp_data),
        .gnt        (gnt),
        .trk_go     (trk_go),
        .trk_finish (trk_finish),
        .trk_data   (trk_data),
        .trk_range  (trk_range),
        .trk_error  (trk_error),
        .res_valid  (res_valid),
        .res_range  (res_range),
        .res_id     (res_id),
        .res_timeout(res_timeout),
        .proto_err  (proto_err)
    );

    always #5 clock = ~clock;

    // Behavioural tracker: latches on go, accumulates while active, and only
    // presents a meaningful range in the finish cycle (0xA5 otherwise).
    logic [WIDTH-1:0] m_mn, m_mx, c_mn, c_mx;
    logic             m_act;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_act <= 1'b0;
            m_mn  <= '0;
            m_mx  <= '0;
        end else if (trk_go) begin
            m_act <= 1'b1;
            m_mn  <= trk_data;
            m_mx  <= trk_data;
        end else if (trk_finish) begin
            m_act <= 1'b0;
        end else if (m_act) begin
            m_mn <= c_mn;
            m_mx <= c_mx;
        end
    end

    always_comb begin
        c_mn      = (trk_data < m_mn) ? trk_data : m_mn;
        c_mx      = (trk_data > m_mx) ? trk_data : m_mx;
        trk_range = trk_finish ? (c_mx - c_mn) : 8'hA5;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_smp(input int id, input logic [WIDTH-1:0] d, input logic last);
        smp_valid = '0;
        smp_last  = '0;
        smp_valid[id] = 1'b1;
        smp_last[id]  = last;
        smp_data[id*WIDTH +: WIDTH] = d;
        tick();
        smp_valid = '0;
        smp_last  = '0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        smp_valid = '0;
        smp_last  = '0;
        trk_error = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = 2'b11;
        smp_valid = '0;
        smp_last  = '0;
        smp_data  = '0;
        trk_error = 1'b0;
        tick();
        tick();
        nvec++; if ({gnt, trk_go, trk_finish, trk_data, res_valid, res_range, res_id, res_timeout, proto_err} !== '0) begin nerr++; $display("FAIL reset_outputs: got gnt=%b go=%b fin=%b data=%0d rv=%b rr=%0d id=%0d to=%b pe=%b want all 0", gnt, trk_go, trk_finish, trk_data, res_valid, res_range, res_id, res_timeout, proto_err); end
        req     = '0;
        reset_n = 1'b1;
        tick();
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL reset_no_grant: got %b want 00", gnt); end
    endtask

    task automatic test_basic();
        req = 2'b01;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t1_gnt: got %b want 01", gnt); end
        drive_smp(0, 8'd5, 1'b0);
        nvec++; if ({trk_go, trk_finish} !== 2'b10) begin nerr++; $display("FAIL t1_go: got go=%b fin=%b want go=1 fin=0", trk_go, trk_finish); end
        nvec++; if (trk_data !== 8'd5) begin nerr++; $display("FAIL t1_go_data: got %0d want 5", trk_data); end
        drive_smp(0, 8'd9, 1'b0);
        nvec++; if ({trk_go, trk_data} !== {1'b0, 8'd9}) begin nerr++; $display("FAIL t1_s9: got go=%b data=%0d want go=0 data=9", trk_go, trk_data); end
        tick();
        tick();
        nvec++; if ({trk_finish, trk_data} !== {1'b0, 8'd9}) begin nerr++; $display("FAIL t1_gap_hold: got fin=%b data=%0d want fin=0 data=9", trk_finish, trk_data); end
        drive_smp(0, 8'd3, 1'b0);
        nvec++; if ({gnt, trk_data} !== {2'b01, 8'd3}) begin nerr++; $display("FAIL t1_s3: got gnt=%b data=%0d want gnt=01 data=3", gnt, trk_data); end
        req = 2'b00;
        drive_smp(0, 8'd7, 1'b1);
        nvec++; if ({trk_finish, trk_go, trk_data} !== {1'b1, 1'b0, 8'd7}) begin nerr++; $display("FAIL t1_finish: got fin=%b go=%b data=%0d want fin=1 go=0 data=7", trk_finish, trk_go, trk_data); end
        nvec++; if ({gnt, res_valid} !== 3'b000) begin nerr++; $display("FAIL t1_end_cycle: got gnt=%b rv=%b want 00/0", gnt, res_valid); end
        tick();
        nvec++; if ({res_valid, res_range, res_id, res_timeout, trk_finish} !== {1'b1, 8'd6, 1'b0, 1'b0, 1'b0}) begin nerr++; $display("FAIL t1_result: got rv=%b rr=%0d id=%0d to=%b fin=%b want 1/6/0/0/0", res_valid, res_range, res_id, res_timeout, trk_finish); end
        tick();
        nvec++; if ({res_valid, res_range} !== {1'b0, 8'd6}) begin nerr++; $display("FAIL t1_result_hold: got rv=%b rr=%0d want 0/6", res_valid, res_range); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 2'b11;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t2_gnt0: got %b want 01", gnt); end
        drive_smp(0, 8'd20, 1'b0);
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t2_gnt0_stable: got %b want 01", gnt); end
        drive_smp(0, 8'd30, 1'b1);
        nvec++; if ({trk_finish, gnt} !== 3'b100) begin nerr++; $display("FAIL t2_fin0: got fin=%b gnt=%b want 1/00", trk_finish, gnt); end
        tick();
        nvec++; if ({res_valid, res_id, res_range, gnt} !== {1'b1, 1'b0, 8'd10, 2'b10}) begin nerr++; $display("FAIL t2_res0: got rv=%b id=%0d rr=%0d gnt=%b want 1/0/10/10", res_valid, res_id, res_range, gnt); end
        drive_smp(1, 8'd50, 1'b0);
        nvec++; if ({trk_go, trk_data, gnt} !== {1'b1, 8'd50, 2'b10}) begin nerr++; $display("FAIL t2_go1: got go=%b data=%0d gnt=%b want 1/50/10", trk_go, trk_data, gnt); end
        drive_smp(1, 8'd45, 1'b1);
        nvec++; if (trk_finish !== 1'b1) begin nerr++; $display("FAIL t2_fin1: got %b want 1", trk_finish); end
        tick();
        nvec++; if ({res_valid, res_id, res_range, gnt} !== {1'b1, 1'b1, 8'd5, 2'b01}) begin nerr++; $display("FAIL t2_res1: got rv=%b id=%0d rr=%0d gnt=%b want 1/1/5/01", res_valid, res_id, res_range, gnt); end
        drive_smp(0, 8'd100, 1'b0);
        req = 2'b00;
        drive_smp(0, 8'd101, 1'b1);
        tick();
        nvec++; if ({res_valid, res_id, res_range, gnt} !== {1'b1, 1'b0, 8'd1, 2'b00}) begin nerr++; $display("FAIL t2_res2: got rv=%b id=%0d rr=%0d gnt=%b want 1/0/1/00", res_valid, res_id, res_range, gnt); end
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t3_gnt: got %b want 01", gnt); end
        req = 2'b00;
        drive_smp(0, 8'd42, 1'b1);
        nvec++; if ({trk_go, trk_finish, trk_data} !== {1'b1, 1'b0, 8'd42}) begin nerr++; $display("FAIL t3_go: got go=%b fin=%b data=%0d want 1/0/42", trk_go, trk_finish, trk_data); end
        tick();
        nvec++; if ({trk_go, trk_finish, trk_data, res_valid} !== {1'b0, 1'b1, 8'd42, 1'b0}) begin nerr++; $display("FAIL t3_fin1: got go=%b fin=%b data=%0d rv=%b want 0/1/42/0", trk_go, trk_finish, trk_data, res_valid); end
        tick();
        nvec++; if ({res_valid, res_range, res_id, res_timeout} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin nerr++; $display("FAIL t3_result: got rv=%b rr=%0d id=%0d to=%b want 1/0/0/0", res_valid, res_range, res_id, res_timeout); end
    endtask

    task automatic test_timeout();
        int bad;
        req = 2'b10;
        tick();
        nvec++; if (gnt !== 2'b10) begin nerr++; $display("FAIL t4_gnt1: got %b want 10", gnt); end
        drive_smp(1, 8'd10, 1'b0);
        nvec++; if ({trk_go, trk_data} !== {1'b1, 8'd10}) begin nerr++; $display("FAIL t4_go: got go=%b data=%0d want 1/10", trk_go, trk_data); end
        req = 2'b11;
        bad = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (trk_finish || trk_go || res_valid || gnt != 2'b10) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL t4_early_abort: got %0d bad cycles want 0", bad); end
        tick();
        nvec++; if ({trk_finish, trk_go, gnt, trk_data} !== {1'b1, 1'b0, 2'b00, 8'd10}) begin nerr++; $display("FAIL t4_abort_fin: got fin=%b go=%b gnt=%b data=%0d want 1/0/00/10", trk_finish, trk_go, gnt, trk_data); end
        tick();
        nvec++; if ({res_valid, res_timeout, res_range, res_id} !== {1'b1, 1'b1, 8'd0, 1'b1}) begin nerr++; $display("FAIL t4_result: got rv=%b to=%b rr=%0d id=%0d want 1/1/0/1", res_valid, res_timeout, res_range, res_id); end
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t4_next_gnt: got %b want 01", gnt); end
        // req0 now owns a session but never sends a sample: abort from GRANT
        req = 2'b00;
        bad = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (trk_finish || trk_go || res_valid || gnt != 2'b01) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL t4g_early_abort: got %0d bad cycles want 0", bad); end
        tick();
        nvec++; if ({gnt, trk_finish, trk_go, res_valid} !== 5'b00000) begin nerr++; $display("FAIL t4g_abort: got gnt=%b fin=%b go=%b rv=%b want 00/0/0/0", gnt, trk_finish, trk_go, res_valid); end
        tick();
        nvec++; if ({res_valid, res_timeout, res_range, res_id, trk_finish} !== {1'b1, 1'b1, 8'd0, 1'b0, 1'b0}) begin nerr++; $display("FAIL t4g_result: got rv=%b to=%b rr=%0d id=%0d fin=%b want 1/1/0/0/0", res_valid, res_timeout, res_range, res_id, trk_finish); end
    endtask

    task automatic test_reset_mid_session();
        int bad;
        req = 2'b01;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t5_gnt: got %b want 01", gnt); end
        drive_smp(0, 8'd5, 1'b0);
        drive_smp(0, 8'd9, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        nvec++; if ({gnt, trk_go, trk_finish, trk_data, res_valid, res_range, res_id, res_timeout, proto_err} !== '0) begin nerr++; $display("FAIL t5_async_clear: got gnt=%b data=%0d rv=%b to=%b want all 0", gnt, trk_data, res_valid, res_timeout); end
        bad = 0;
        tick();
        if (res_valid || gnt != 2'b00 || trk_finish) bad++;
        tick();
        if (res_valid || gnt != 2'b00 || trk_finish) bad++;
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL t5_held_reset: got %0d bad cycles want 0", bad); end
        req     = 2'b00;
        reset_n = 1'b1;
        tick();
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL t5_no_result: got %b want 0", res_valid); end
        test_basic();
    endtask

    task automatic test_ignore_other();
        logic [5:0] v0, l0, v1;
        logic [7:0] d0 [6];
        logic [7:0] ed [6];
        v0 = 6'b101001;
        l0 = 6'b100000;
        v1 = 6'b110101;
        d0 = '{8'd8, 8'd0, 8'd0, 8'd2, 8'd0, 8'd4};
        ed = '{8'd8, 8'd8, 8'd8, 8'd2, 8'd2, 8'd4};
        req = 2'b01;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL t6_gnt: got %b want 01", gnt); end
        req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            smp_valid = {v1[i], v0[i]};
            smp_last  = {v1[i], l0[i]};
            smp_data  = {8'd255, d0[i]};
            tick();
            nvec++; if ({trk_data, trk_go, trk_finish} !== {ed[i], (i == 0), (i == 5)}) begin nerr++; $display("FAIL t6_step%0d: got data=%0d go=%b fin=%b want %0d/%b/%b", i, trk_data, trk_go, trk_finish, ed[i], (i == 0), (i == 5)); end
        end
        smp_valid = '0;
        smp_last  = '0;
        tick();
        nvec++; if ({res_valid, res_range, res_id, res_timeout} !== {1'b1, 8'd6, 1'b0, 1'b0}) begin nerr++; $display("FAIL t6_result: got rv=%b rr=%0d id=%0d to=%b want 1/6/0/0", res_valid, res_range, res_id, res_timeout); end
        nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL t6_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_proto_err();
        trk_error = 1'b1;
        tick();
        trk_error = 1'b0;
        nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL pe_set: got %b want 1", proto_err); end
        tick();
        tick();
        nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL pe_sticky: got %b want 1", proto_err); end
        reset_n = 1'b0;
        #1;
        nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL pe_reset: got %b want 0", proto_err); end
        tick();
        reset_n = 1'b1;
        tick();
        nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL pe_after_reset: got %b want 0", proto_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_single();
        test_timeout();
        test_reset_mid_session();
        test_ignore_other();
        test_proto_err();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
